multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multi-cycle control FSM for the RV32I core. It sequences the shared instruction/data memory port, the instruction register, the PC and the register-file write enable across FETCH/DECODE/EXEC/MEM/WB. It sits beside `Control_unit`: `Control_unit` supplies the per-instruction datapath selects, and this block gates its `RUWr`/`DMWr` in time and handles the single-port memory handshake.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16: maximum cycles a memory request may wait before trapping. Used only with `MEM_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `OpCode`  in  7  opcode field from the instruction register
- `MemReady`  in  1  memory acknowledge; the transfer completes in any cycle where `MemReq && MemReady`
- `MemReq`  out  1  memory request
- `MemWe`  out  1  memory write; asserted only during a store in MEM
- `MemAddrSel`  out  1  address source: 0 = PC, 1 = ALU result
- `IRWr`  out  1  load the instruction register
- `PCWr`  out  1  commit the next PC
- `RUWrEn`  out  1  qualified register-file write
- `Halted`  out  1  high in HALT or TRAP
- `TrapCause`  out  2  trap reason: 00 none, 01 illegal opcode, 10 memory timeout
- `RetireCount`  out  32  retired-instruction counter
- `State`  out  3  current state encoding

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6. Outputs are Moore-decoded from the state register plus `MemReady`.
- **FETCH**
  - Drives `MemReq=1`, `MemAddrSel=0`.
  - On `MemReady=1`: `IRWr=1` that cycle, next state DECODE.
  - Otherwise stays in FETCH with the request held.
- **DECODE** (1 cycle). Decides on `OpCode`:
  - 1110011 (ECALL) → HALT.
  - Any opcode outside the RV32I set {0110011, 0010011, 0000011, 1100111, 1100011, 0100011, 1101111, 0110111, 0010111} → TRAP with cause 01.
  - All other opcodes → EXEC.
- **EXEC** (1 cycle): load (0000011) or store (0100011) → MEM; all others → WB.
- **MEM**
  - Drives `MemReq=1`, `MemAddrSel=1`, and `MemWe=1` when the opcode is a store.
  - On `MemReady=1`: a load goes to WB; a store asserts `PCWr=1` and retires, then goes to FETCH.
- **WB** (1 cycle)
  - `PCWr=1`.
  - `RUWrEn=1` unless the opcode is a branch (1100011).
  - Retires, then goes to FETCH.
- **HALT / TRAP**: terminal. All strobes are 0 and `Halted=1`. Only `rst` exits.
- **Retire**: the `PCWr` cycle. `RetireCount` increments at that edge and wraps 0xFFFF_FFFF → 0. HALT/TRAP entries do not retire.
- `MemReady` is ignored whenever `MemReq=0`.

## Timing
- **Reset values**
  - State = FETCH, `RetireCount=0`, `TrapCause=00`.
  - All strobes (`MemReq`, `MemWe`, `IRWr`, `PCWr`, `RUWrEn`) and `Halted` are 0 while `rst` is high.
  - `MemReq` rises in the first cycle after `rst` falls.
- **Latency with zero-wait memory**
  - ALU, branch, jump, LUI and AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Each wait cycle at FETCH or MEM adds 1.
- **Reset mid-operation** (any state, including a pending MEM write): abort. No `PCWr`/`RUWrEn` is issued, and `RetireCount` and `TrapCause` clear.
- **OpCode sampling**: `OpCode` is sampled only in DECODE through WB. Changes on `OpCode` in FETCH are don't-care.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A wait counter counts cycles with `MemReq && !MemReady`, clears on transfer completion, and clears on every state change.
  - When the counter reaches `TIMEOUT_CYCLES`, the FSM goes to TRAP with `TrapCause=10` on the next edge. No `IRWr`/`PCWr` is issued for that transfer.
- `MEM_TIMEOUT_EN` undefined: the FSM waits indefinitely, no counter is present, and `TrapCause` is only ever 00 or 01.

## Structure
- Shared package `riscv_pkg`:
  - state enum `seq_state_t` (3-bit, encodings above);
  - opcode constants (`OP_RTYPE`, `OP_IARITH`, `OP_LOAD`, `OP_JALR`, `OP_BRANCH`, `OP_STORE`, `OP_JAL`, `OP_LUI`, `OP_AUIPC`, `OP_SYSTEM`);
  - trap-cause constants.
- `Control_unit` is expected to migrate to the same opcode constants.
- One sub-module, `mem_wait_timer`: holds the wait counter and expiry flag. It is instantiated only under `MEM_TIMEOUT_EN`.

## Test plan
- **ADD**: `rst` then `OpCode=0110011`, `MemReady=1` constant → State 0,1,2,4,0; `IRWr` in cycle 1, `PCWr` and `RUWrEn` in cycle 4, `RetireCount=1`.
- **Load with wait states**: `OpCode=0000011`, `MemReady` low 2 cycles in FETCH and 3 cycles in MEM → retires 10 cycles after reset release, with `MemAddrSel=1` throughout MEM and `MemWe=0`.
- **Store and branch**: store → `MemWe=1` only in MEM, `PCWr` on MEM completion, no `RUWrEn`, 4 cycles. BEQ (1100011) → `PCWr=1` and `RUWrEn=0` in WB.
- **Illegal and ECALL**: `OpCode=0000000` → TRAP, `TrapCause=01`, `Halted=1`, `RetireCount` unchanged. `OpCode=1110011` → HALT, `TrapCause=00`. Both stay put until `rst`.
- **Reset mid-MEM and wrap**: `rst` asserted during a store in MEM → no `PCWr`, next state FETCH, count 0. Separately, forcing `RetireCount` to 0xFFFF_FFFF and retiring one instruction → 0.
- **Timeout** (`MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES=16`): `MemReady` held 0 in FETCH → TRAP with `TrapCause=10` exactly 16 wait cycles after FETCH entry. Without the macro, the FSM still sits in FETCH after 1000 cycles.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: sequencer states, opcode constants and trap causes.
package riscv_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned TRAP_W   = 2;
    localparam int unsigned RETIRE_W = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_TRAP   = 3'd6
    } seq_state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_IARITH = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_SYSTEM = 7'b1110011;

    localparam logic [TRAP_W-1:0] TRAP_NONE    = 2'b00;
    localparam logic [TRAP_W-1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [TRAP_W-1:0] TRAP_TIMEOUT = 2'b10;

    // True for opcodes the core executes (ECALL is handled separately).
    function automatic logic is_rv32i_op(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_RTYPE, OP_IARITH, OP_LOAD, OP_JALR, OP_BRANCH,
            OP_STORE, OP_JAL, OP_LUI, OP_AUIPC: is_rv32i_op = 1'b1;
            default:                            is_rv32i_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Control/memory-handshake bundle between the sequencer (slave) and its environment (master).
interface multicycle_sequencer_if;
    import riscv_pkg::*;

    logic [OPCODE_W-1:0] OpCode;
    logic                MemReady;
    logic                MemReq;
    logic                MemWe;
    logic                MemAddrSel;
    logic                IRWr;
    logic                PCWr;
    logic                RUWrEn;
    logic                Halted;
    logic [TRAP_W-1:0]   TrapCause;
    logic [RETIRE_W-1:0] RetireCount;
    logic [STATE_W-1:0]  State;

    modport master (
        output OpCode, MemReady,
        input  MemReq, MemWe, MemAddrSel, IRWr, PCWr, RUWrEn,
        input  Halted, TrapCause, RetireCount, State
    );

    modport slave (
        input  OpCode, MemReady,
        output MemReq, MemWe, MemAddrSel, IRWr, PCWr, RUWrEn,
        output Halted, TrapCause, RetireCount, State
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts stalled memory-request cycles; flags the cycle that completes TIMEOUT_CYCLES waits.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_wait,
    input  logic i_clear,
    output logic o_expired_c
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_wait) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // r_cnt holds completed waits, so the current wait is the TIMEOUT_CYCLES-th one.
    assign o_expired_c = i_wait && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Optional memory-request timeout trap enabled by defining MEM_TIMEOUT_EN.
module multicycle_sequencer
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_sequencer_if.slave  bus
);

    seq_state_t          r_state;
    seq_state_t          w_next_state;
    logic [RETIRE_W-1:0] r_retire_cnt;
    logic [TRAP_W-1:0]   r_trap_cause;
    logic [TRAP_W-1:0]   w_trap_cause;
    logic                w_mem_req;
    logic                w_mem_we;
    logic                w_addr_sel;
    logic                w_ir_wr;
    logic                w_pc_wr;
    logic                w_ru_wr;
    logic                w_expired_c;
    logic                w_is_load;
    logic                w_is_store;

    assign w_is_load  = (bus.OpCode == OP_LOAD);
    assign w_is_store = (bus.OpCode == OP_STORE);

`ifdef MEM_TIMEOUT_EN
    logic w_wait;
    logic w_clear;

    assign w_wait  = w_mem_req && !bus.MemReady;
    assign w_clear = (w_mem_req && bus.MemReady) || (w_next_state != r_state);

    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_mem_wait_timer (
        .clk         (clk),
        .rst         (rst),
        .i_wait      (w_wait),
        .i_clear     (w_clear),
        .o_expired_c (w_expired_c)
    );
`else
    assign w_expired_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FETCH;
            r_retire_cnt <= '0;
            r_trap_cause <= TRAP_NONE;
        end else begin
            r_state <= w_next_state;
            if (w_pc_wr) begin
                r_retire_cnt <= r_retire_cnt + RETIRE_W'(1);
            end
            if (w_trap_cause != TRAP_NONE) begin
                r_trap_cause <= w_trap_cause;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_trap_cause = TRAP_NONE;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_addr_sel   = 1'b0;
        w_ir_wr      = 1'b0;
        w_pc_wr      = 1'b0;
        w_ru_wr      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.MemReady) begin
                    w_ir_wr      = 1'b1;
                    w_next_state = ST_DECODE;
                end else if (w_expired_c) begin
                    w_trap_cause = TRAP_TIMEOUT;
                    w_next_state = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (bus.OpCode == OP_SYSTEM) begin
                    w_next_state = ST_HALT;
                end else if (!is_rv32i_op(bus.OpCode)) begin
                    w_trap_cause = TRAP_ILLEGAL;
                    w_next_state = ST_TRAP;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next_state = (w_is_load || w_is_store) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                w_mem_req  = 1'b1;
                w_addr_sel = 1'b1;
                w_mem_we   = w_is_store;
                if (bus.MemReady) begin
                    // Stores have nothing to write back, so they retire here.
                    w_pc_wr      = w_is_store;
                    w_next_state = w_is_store ? ST_FETCH : ST_WB;
                end else if (w_expired_c) begin
                    w_trap_cause = TRAP_TIMEOUT;
                    w_next_state = ST_TRAP;
                end
            end
            ST_WB: begin
                w_pc_wr      = 1'b1;
                w_ru_wr      = (bus.OpCode != OP_BRANCH);
                w_next_state = ST_FETCH;
            end
            ST_HALT, ST_TRAP: begin
                w_next_state = r_state;
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    // Strobes are Moore-decoded and suppressed while reset is asserted.
    assign bus.MemReq      = w_mem_req  && !rst;
    assign bus.MemWe       = w_mem_we   && !rst;
    assign bus.MemAddrSel  = w_addr_sel && !rst;
    assign bus.IRWr        = w_ir_wr    && !rst;
    assign bus.PCWr        = w_pc_wr    && !rst;
    assign bus.RUWrEn      = w_ru_wr    && !rst;
    assign bus.Halted      = ((r_state == ST_HALT) || (r_state == ST_TRAP)) && !rst;
    assign bus.TrapCause   = r_trap_cause;
    assign bus.RetireCount = r_retire_cnt;
    assign bus.State       = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized self-checking bench: per-instruction cycle traces built from the sequencing rules.
module tb_multicycle_sequencer;

    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_ADD    = 7'b0110011;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_ECALL  = 7'b1110011;
    localparam logic [6:0] LEGAL_OPS [9] = '{
        7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1100011,
        7'b0100011, 7'b1101111, 7'b0110111, 7'b0010111
    };

    // One expected cycle: state, strobes {req,we,sel,ir,pc,ru,halted}, trap cause, MemReady to drive.
    typedef struct packed {
        logic [2:0] st;
        logic [6:0] strb;
        logic [1:0] cause;
        logic       rdy;
    } cyc_t;

    logic        clk;
    logic        rst;
    int          n_checks;
    int          n_errors;
    logic [31:0] exp_cnt;
    logic [6:0]  cur_op;
    bit          idle_ready_one;
    cyc_t        plan[$];

    multicycle_sequencer_if bus();

    multicycle_sequencer #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cyc_t mk(input logic [2:0] st, input logic [6:0] strb,
                                input logic [1:0] cause, input logic rdy);
        cyc_t c;
        c.st    = st;
        c.strb  = strb;
        c.cause = cause;
        c.rdy   = rdy;
        return c;
    endfunction

    function automatic logic rnd_idle();
        return idle_ready_one ? 1'b1 : 1'($urandom);
    endfunction

    // Expected trace of one instruction from FETCH entry to retirement or a terminal state.
    task automatic plan_instr(input logic [6:0] op, input int fw, input int mw);
        bit legal;
        bit is_ld;
        bit is_st;
        cur_op = op;
        legal  = 1'b0;
        foreach (LEGAL_OPS[i]) if (LEGAL_OPS[i] == op) legal = 1'b1;
        is_ld = (op == T_LOAD);
        is_st = (op == T_STORE);
        for (int i = 0; i < fw; i++) plan.push_back(mk(3'd0, 7'b1000000, 2'b00, 1'b0));
        plan.push_back(mk(3'd0, 7'b1001000, 2'b00, 1'b1));
        plan.push_back(mk(3'd1, 7'b0000000, 2'b00, rnd_idle()));
        if (op == T_ECALL) begin
            repeat (6) plan.push_back(mk(3'd5, 7'b0000001, 2'b00, rnd_idle()));
            return;
        end
        if (!legal) begin
            repeat (6) plan.push_back(mk(3'd6, 7'b0000001, 2'b01, rnd_idle()));
            return;
        end
        plan.push_back(mk(3'd2, 7'b0000000, 2'b00, rnd_idle()));
        if (is_ld || is_st) begin
            for (int i = 0; i < mw; i++)
                plan.push_back(mk(3'd3, {1'b1, is_st, 1'b1, 4'b0000}, 2'b00, 1'b0));
            if (is_st) begin
                plan.push_back(mk(3'd3, 7'b1110100, 2'b00, 1'b1));
                return;
            end
            plan.push_back(mk(3'd3, 7'b1010000, 2'b00, 1'b1));
        end
        plan.push_back(mk(3'd4, {4'b0000, 1'b1, op != T_BRANCH, 1'b0}, 2'b00, rnd_idle()));
    endtask

    task automatic run_plan();
        cyc_t c;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            @(negedge clk);
            rst          = 1'b0;
            bus.MemReady = c.rdy;
            bus.OpCode   = (c.st == 3'd0 || c.st >= 3'd5) ? 7'($urandom) : cur_op;
            #1;
            check("outputs", 64'({bus.State, bus.MemReq, bus.MemWe, bus.MemAddrSel, bus.IRWr,
                                  bus.PCWr, bus.RUWrEn, bus.Halted, bus.TrapCause}),
                             64'({c.st, c.strb, c.cause}));
            check("retire_cnt", 64'(bus.RetireCount), 64'(exp_cnt));
            if (c.strb[2]) exp_cnt = exp_cnt + 32'd1;
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst          = 1'b1;
            bus.MemReady = (i == 0) ? 1'b1 : 1'($urandom);
            bus.OpCode   = 7'($urandom);
            #1;
            check("rst_strobes", 64'({bus.MemReq, bus.MemWe, bus.MemAddrSel, bus.IRWr,
                                      bus.PCWr, bus.RUWrEn, bus.Halted}), 64'(0));
            if (i > 0) begin
                check("rst_state", 64'({bus.State, bus.TrapCause}), 64'(0));
                check("rst_cnt", 64'(bus.RetireCount), 64'(0));
            end
        end
        exp_cnt = 32'd0;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        exp_cnt        = 32'd0;
        idle_ready_one = 1'b0;
        rst            = 1'b1;
        bus.MemReady   = 1'b0;
        bus.OpCode     = 7'd0;

        // ADD with MemReady held high.
        do_reset(3);
        idle_ready_one = 1'b1;
        plan_instr(T_ADD, 0, 0);
        run_plan();
        idle_ready_one = 1'b0;

        // Load with 2 fetch and 3 memory wait cycles, then store and branch.
        do_reset(2);
        plan_instr(T_LOAD, 2, 3);
        run_plan();
        plan_instr(T_STORE, 0, 0);
        run_plan();
        plan_instr(T_BRANCH, 1, 0);
        run_plan();

        // Random legal instruction stream with random wait states.
        for (int n = 0; n < 60; n++) begin
            plan_instr(LEGAL_OPS[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3));
            run_plan();
        end

        // Illegal opcode traps without retiring; ECALL halts.
        plan_instr(7'b0000000, 1, 0);
        run_plan();
        do_reset(2);
        plan_instr(T_LUI, 0, 0);
        run_plan();
        plan_instr(T_ECALL, 0, 0);
        run_plan();

        // Reset while a store waits in MEM.
        do_reset(2);
        plan_instr(T_ADD, 0, 0);
        run_plan();
        plan_instr(T_STORE, 0, 5);
        repeat (4) void'(plan.pop_back());
        run_plan();
        do_reset(2);
        plan_instr(T_ADD, 0, 0);
        run_plan();

        // Retire counter wraps from all-ones to zero.
        @(posedge clk);
        #1;
        force dut.r_retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_cnt;
        exp_cnt = 32'hFFFF_FFFF;
        plan_instr(T_ADD, 0, 0);
        run_plan();
        plan_instr(T_LUI, 0, 0);
        run_plan();

`ifdef MEM_TIMEOUT_EN
        do_reset(2);
        cur_op = T_ADD;
        repeat (16) plan.push_back(mk(3'd0, 7'b1000000, 2'b00, 1'b0));
        repeat (4) plan.push_back(mk(3'd6, 7'b0000001, 2'b10, 1'($urandom)));
        run_plan();
`else
        do_reset(2);
        cur_op = T_ADD;
        repeat (1000) plan.push_back(mk(3'd0, 7'b1000000, 2'b00, 1'b0));
        run_plan();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
